// File: rtl/instr_fetch_sched_if.sv
// Bundle of the fetch scheduler's loader, memory and decode-side signals.
// The scheduler connects through the master modport; the environment uses slave.
interface instr_fetch_sched_if #(
    parameter int AW = 4,
    parameter int DW = 16
);
    logic          start;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          mem_wren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_q;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          halted;

    modport master (
        input  start, redirect, redirect_pc, ld_valid, ld_addr, ld_data, mem_q, instr_ready,
        output ld_ready, mem_wren, mem_addr, mem_din, instr, instr_pc, instr_valid, halted
    );

    modport slave (
        output start, redirect, redirect_pc, ld_valid, ld_addr, ld_data, mem_q, instr_ready,
        input  ld_ready, mem_wren, mem_addr, mem_din, instr, instr_pc, instr_valid, halted
    );
endinterface

// File: rtl/instr_fetch_sched.sv
// Instruction fetch scheduler: generates PCs for a single-port synchronous
// instruction memory, absorbs its 1-cycle read latency through a 2-entry buffer,
// and shares the port with a loader under bounded starvation.
module instr_fetch_sched #(
    parameter int AW           = 4,
    parameter int DW           = 16,
    parameter int RESET_PC     = 0,
    parameter int STARVE_MAX   = 3,
    parameter int HALT_ON_ZERO = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_sched_if.master  bus
);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc;
    logic          inflight;
    logic [AW-1:0] inflight_tag;
    logic [SW-1:0] starve_cnt;
    logic [DW-1:0] fifo_data [2];
    logic [AW-1:0] fifo_pc   [2];
    logic          rd_ptr, wr_ptr;
    logic [1:0]    count;

    logic          fetch_elig, fetch_issue, ld_grant, zero_ret, push, pop;
    logic [1:0]    occ;

    assign bus.instr       = fifo_data[rd_ptr];
    assign bus.instr_pc    = fifo_pc[rd_ptr];
    assign bus.instr_valid = (count != 2'd0);
    assign bus.halted      = (state_q == HALT);
    assign bus.mem_wren    = ld_grant;
    assign bus.mem_addr    = ld_grant ? bus.ld_addr : pc;
    assign bus.mem_din     = bus.ld_data;

    // Arbitration, fetch eligibility, buffer push/pop and next state.
    always_comb begin
        state_d      = state_q;
        bus.ld_ready = 1'b1;
        pop          = (count != 2'd0) && bus.instr_ready;
        // Occupancy counts this cycle's pop so a steady stream issues every cycle.
        occ          = count - {1'b0, pop} + {1'b0, inflight};
        fetch_elig   = (state_q == RUN) && !bus.redirect && (occ < 2'd2);
        if (state_q == RUN) begin
            bus.ld_ready = !(fetch_elig && (starve_cnt == SW'(STARVE_MAX)));
        end
        ld_grant    = bus.ld_valid && bus.ld_ready;
        fetch_issue = fetch_elig && !ld_grant;
        zero_ret    = inflight && !bus.redirect && (HALT_ON_ZERO != 0) && (bus.mem_q == '0);
        push        = inflight && !bus.redirect && !zero_ret;

        case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN:  if (!bus.redirect && zero_ret) state_d = HALT;
            HALT: if (bus.redirect) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // PC, in-flight read tracking, instruction buffer and starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= AW'(RESET_PC);
            inflight     <= 1'b0;
            inflight_tag <= '0;
            starve_cnt   <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            count        <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else begin
            if (bus.redirect) begin
                pc       <= bus.redirect_pc;
                inflight <= 1'b0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
                count    <= '0;
            end else begin
                if (zero_ret) begin
                    // Resume point is the zero word; a read issued alongside is dropped.
                    pc       <= inflight_tag;
                    inflight <= 1'b0;
                end else begin
                    inflight <= fetch_issue;
                    if (fetch_issue) begin
                        pc           <= pc + 1'b1;
                        inflight_tag <= pc;
                    end
                end
                if (push) begin
                    fifo_data[wr_ptr] <= bus.mem_q;
                    fifo_pc[wr_ptr]   <= inflight_tag;
                    wr_ptr            <= ~wr_ptr;
                end
                if (pop) rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end

            if (state_q != RUN || fetch_issue)
                starve_cnt <= '0;
            else if (ld_grant && fetch_elig)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_fetch_sched.sv
// Directed bench for instr_fetch_sched with a behavioural 16x16 synchronous memory.
module tb_instr_fetch_sched;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    instr_fetch_sched_if #(.AW(4), .DW(16)) bus ();

    instr_fetch_sched #(
        .AW(4), .DW(16), .RESET_PC(0), .STARVE_MAX(3), .HALT_ON_ZERO(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [15:0] mem [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory: read returns the pre-write contents.
    always @(posedge clk) begin
        if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_din;
        bus.mem_q <= mem[bus.mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_instr(input string tag, input logic [15:0] d, input logic [3:0] a);
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        chk({tag, "_instr"}, 32'(bus.instr), 32'(d));
        chk({tag, "_pc"}, 32'(bus.instr_pc), 32'(a));
    endtask

    task automatic expect_reset();
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_instr", 32'(bus.instr), 32'd0);
        chk("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
        #1;
        chk("rst_wren", 32'(bus.mem_wren), 32'd0);
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        #1;
        chk("load_ready", 32'(bus.ld_ready), 32'd1);
        chk("load_wren", 32'(bus.mem_wren), 32'd1);
        step();
        bus.ld_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] pattern;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.ld_valid = 1'b0;
        bus.ld_addr = '0;
        bus.ld_data = '0;
        bus.instr_ready = 1'b1;

        step();
        step();
        expect_reset();
        rst = 1'b0;

        for (int i = 0; i < 16; i++) load(4'(i), 16'(i + 1));

        // Start: first valid two edges later, then one per cycle.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_lat0", 32'(bus.instr_valid), 32'd0);
        step();
        chk("start_lat1", 32'(bus.instr_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            expect_instr("stream", 16'(k + 1), 4'(k));
        end

        // Decode stalls 5 cycles while instr 6 (pc 5) is presented.
        bus.instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            expect_instr("stall", 16'd6, 4'd5);
        end
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            expect_instr("resume", 16'(k + 7), 4'(k + 6));
        end

        // Fill buffer to two entries, then redirect to 14 (wrap through 15 -> 0).
        bus.instr_ready = 1'b0;
        step();
        expect_instr("full", 16'd10, 4'd9);
        bus.redirect = 1'b1;
        bus.redirect_pc = 4'd14;
        step();
        bus.redirect = 1'b0;
        bus.instr_ready = 1'b1;
        chk("redir_flush0", 32'(bus.instr_valid), 32'd0);
        step();
        chk("redir_flush1", 32'(bus.instr_valid), 32'd0);
        step();
        expect_instr("wrap14", 16'd15, 4'd14);
        step();
        expect_instr("wrap15", 16'd16, 4'd15);
        step();
        expect_instr("wrap0", 16'd1, 4'd0);

        // Redirect with a read in flight.
        bus.redirect = 1'b1;
        bus.redirect_pc = 4'd8;
        step();
        bus.redirect = 1'b0;
        chk("redir2_flush0", 32'(bus.instr_valid), 32'd0);
        step();
        chk("redir2_flush1", 32'(bus.instr_valid), 32'd0);
        step();
        expect_instr("redir2_a", 16'd9, 4'd8);
        step();
        expect_instr("redir2_b", 16'd10, 4'd9);

        // Loader held high in RUN: three grants then one forced fetch, repeating.
        pattern = 8'b0111_0111;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 4'd12;
        bus.ld_data  = 16'd13;
        for (int j = 0; j < 8; j++) begin
            #1;
            chk("starve_ready", 32'(bus.ld_ready), 32'(pattern[j]));
            chk("starve_wren", 32'(bus.mem_wren), 32'(pattern[j]));
            if (!pattern[j]) chk("starve_addr", 32'(bus.mem_addr), 32'(11 + j / 4));
            step();
        end
        bus.ld_valid = 1'b0;

        // Reset mid-run.
        rst = 1'b1;
        step();
        expect_reset();
        rst = 1'b0;

        // Zero word at address 3 halts fetch.
        load(4'd3, 16'd0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            expect_instr("pre_halt", 16'(k + 1), 4'(k));
            chk("pre_halt_halted", 32'(bus.halted), 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk("halt_halted", 32'(bus.halted), 32'd1);
            chk("halt_valid", 32'(bus.instr_valid), 32'd0);
            #1;
            chk("halt_wren", 32'(bus.mem_wren), 32'd0);
            chk("halt_ld_ready", 32'(bus.ld_ready), 32'd1);
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 4'd0;
        step();
        bus.redirect = 1'b0;
        chk("unhalt_halted", 32'(bus.halted), 32'd0);
        chk("unhalt_valid0", 32'(bus.instr_valid), 32'd0);
        step();
        chk("unhalt_valid1", 32'(bus.instr_valid), 32'd0);
        step();
        expect_instr("unhalt", 16'd1, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
